// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-way SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_AW = 20;
  localparam int unsigned SRAM_DW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_e;

  typedef enum logic [1:0] {REQ_VGA, REQ_GB, REQ_HOST} req_id_e;

  // Game Boy byte address -> SRAM word address inside its window (wraps at 2^20).
  function automatic logic [SRAM_AW-1:0] gb_word_addr(input logic [SRAM_AW-1:0] base,
                                                      input logic [15:0]        byte_addr);
    return base + {5'b0, byte_addr[15:1]};
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker; the pointer moves to the loser whenever a grant is taken.
module sram_rr_pick (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_req_a && (!i_req_b || !r_ptr)) begin
      o_gnt = 2'b01;
    end else if (i_req_b) begin
      o_gnt = 2'b10;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_take && (|o_gnt)) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM among VGA (highest priority), Game Boy and host (round-robin)
// through a fixed IDLE -> ACCESS -> RECOVER sequence with fully registered pin outputs.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned        ACCESS_CYCLES = 2,
  parameter logic [SRAM_AW-1:0] GB_BASE       = 20'h10000
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               vga_req,
  input  logic [SRAM_AW-1:0] vga_addr,
  output logic               vga_ack,
  output logic [SRAM_DW-1:0] vga_rdata,
  input  logic               gb_req,
  input  logic               gb_we,
  input  logic [15:0]        gb_addr,
  input  logic [7:0]         gb_wdata,
  output logic               gb_ack,
  output logic [7:0]         gb_rdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [1:0]         host_be,
  input  logic [SRAM_DW-1:0] host_wdata,
  output logic               host_ack,
  output logic [SRAM_DW-1:0] host_rdata,
  inout  wire  [SRAM_DW-1:0] sram_DQ,
  output logic [SRAM_AW-1:0] sram_ADDR,
  output logic               sram_LB_N,
  output logic               sram_UB_N,
  output logic               sram_CE_N,
  output logic               sram_OE_N,
  output logic               sram_WE_N
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_e             r_state;
  req_id_e            r_owner;
  logic [3:0]         r_cnt;
  logic [1:0]         r_be;
  logic [SRAM_DW-1:0] r_wdata;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_dq_oe;
  logic               r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n;
  logic               r_vga_ack, r_gb_ack, r_host_ack;
  logic [SRAM_DW-1:0] r_vga_rdata, r_host_rdata;
  logic [7:0]         r_gb_rdata;

  logic [1:0]         w_rr_gnt;
  logic               w_grant, w_take, w_gnt_we;
  req_id_e            w_gnt_id;
  logic [SRAM_AW-1:0] w_gnt_addr;
  logic [1:0]         w_gnt_be;
  logic [SRAM_DW-1:0] w_gnt_wdata;

  sram_rr_pick u_rr_pick (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_req_a (gb_req),
    .i_req_b (host_req),
    .i_take  (w_take),
    .o_gnt   (w_rr_gnt)
  );

  always_comb begin
    w_grant     = 1'b0;
    w_take      = 1'b0;
    w_gnt_id    = REQ_VGA;
    w_gnt_addr  = vga_addr;
    w_gnt_we    = 1'b0;
    w_gnt_be    = 2'b11;
    w_gnt_wdata = '0;
    if (r_state == IDLE) begin
      if (vga_req) begin
        w_grant = 1'b1;
      end else if (w_rr_gnt[0]) begin
        w_grant     = 1'b1;
        w_take      = 1'b1;
        w_gnt_id    = REQ_GB;
        w_gnt_addr  = gb_word_addr(GB_BASE, gb_addr);
        w_gnt_we    = gb_we;
        w_gnt_be    = gb_addr[0] ? 2'b10 : 2'b01;
        w_gnt_wdata = {2{gb_wdata}};
      end else if (w_rr_gnt[1]) begin
        w_grant     = 1'b1;
        w_take      = 1'b1;
        w_gnt_id    = REQ_HOST;
        w_gnt_addr  = host_addr;
        w_gnt_we    = host_we;
        w_gnt_be    = host_be;
        w_gnt_wdata = host_wdata;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state      <= IDLE;
      r_owner      <= REQ_VGA;
      r_cnt        <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_addr       <= '0;
      r_dq_oe      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_vga_ack    <= 1'b0;
      r_gb_ack     <= 1'b0;
      r_host_ack   <= 1'b0;
      r_vga_rdata  <= '0;
      r_gb_rdata   <= '0;
      r_host_rdata <= '0;
    end else begin
      r_vga_ack  <= 1'b0;
      r_gb_ack   <= 1'b0;
      r_host_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_gnt_id;
            r_addr  <= w_gnt_addr;
            r_be    <= w_gnt_be;
            r_wdata <= w_gnt_wdata;
            r_cnt   <= '0;
            r_dq_oe <= w_gnt_we;
            r_ce_n  <= 1'b0;
            r_oe_n  <= w_gnt_we;
            r_we_n  <= ~w_gnt_we;
            r_lb_n  <= ~w_gnt_be[0];
            r_ub_n  <= ~w_gnt_be[1];
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == LAST_CNT) begin
            case (r_owner)
              REQ_VGA: begin
                r_vga_rdata <= sram_DQ;
                r_vga_ack   <= 1'b1;
              end
              REQ_GB: begin
                r_gb_rdata <= r_be[1] ? sram_DQ[15:8] : sram_DQ[7:0];
                r_gb_ack   <= 1'b1;
              end
              default: begin
                r_host_rdata <= sram_DQ;
                r_host_ack   <= 1'b1;
              end
            endcase
            // Strobes release here; DQ stays driven through RECOVER for write data hold.
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_state <= RECOVER;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RECOVER: begin
          r_dq_oe <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_DQ    = r_dq_oe ? r_wdata : 'z;
  assign sram_ADDR  = r_addr;
  assign sram_CE_N  = r_ce_n;
  assign sram_OE_N  = r_oe_n;
  assign sram_WE_N  = r_we_n;
  assign sram_LB_N  = r_lb_n;
  assign sram_UB_N  = r_ub_n;
  assign vga_ack    = r_vga_ack;
  assign gb_ack     = r_gb_ack;
  assign host_ack   = r_host_ack;
  assign vga_rdata  = r_vga_rdata;
  assign gb_rdata   = r_gb_rdata;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a behavioural SRAM plus a second instance with ACCESS_CYCLES=5.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vga_req, gb_req, gb_we, host_req, host_we;
  logic [19:0] vga_addr, host_addr;
  logic [15:0] gb_addr, host_wdata;
  logic [7:0]  gb_wdata;
  logic [1:0]  host_be;
  logic        vga_ack, gb_ack, host_ack;
  logic [15:0] vga_rdata, host_rdata;
  logic [7:0]  gb_rdata;
  wire  [15:0] sram_DQ;
  logic [19:0] sram_ADDR;
  logic        sram_LB_N, sram_UB_N, sram_CE_N, sram_OE_N, sram_WE_N;

  sram_arbiter dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_ack     (vga_ack),
    .vga_rdata   (vga_rdata),
    .gb_req      (gb_req),
    .gb_we       (gb_we),
    .gb_addr     (gb_addr),
    .gb_wdata    (gb_wdata),
    .gb_ack      (gb_ack),
    .gb_rdata    (gb_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_be     (host_be),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .sram_DQ     (sram_DQ),
    .sram_ADDR   (sram_ADDR),
    .sram_LB_N   (sram_LB_N),
    .sram_UB_N   (sram_UB_N),
    .sram_CE_N   (sram_CE_N),
    .sram_OE_N   (sram_OE_N),
    .sram_WE_N   (sram_WE_N)
  );

  // Undriven DQ floats high so a released bus reads 16'hFFFF.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (sram_DQ[g]);
  end

  // Sparse SRAM model: the few addresses used here map to distinct slots.
  logic [15:0] mem [4096];
  function automatic logic [11:0] idx(input logic [19:0] a);
    return {a[16], a[14], a[9:0]};
  endfunction
  assign sram_DQ = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? mem[idx(sram_ADDR)] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_CE_N && !sram_WE_N) begin
      if (!sram_LB_N) mem[idx(sram_ADDR)][7:0] <= sram_DQ[7:0];
      if (!sram_UB_N) mem[idx(sram_ADDR)][15:8] <= sram_DQ[15:8];
    end
  end

  // Second instance with long strobes; its "SRAM" returns a constant word.
  logic        h5_req;
  logic [19:0] a5;
  logic [15:0] d5, vr5, hr5;
  logic [7:0]  gr5;
  logic        va5, ga5, ha5, lb5, ub5, ce5, oe5, we5;
  wire  [15:0] dq5;
  assign dq5 = (!ce5 && !oe5) ? 16'h1234 : 16'hzzzz;

  sram_arbiter #(.ACCESS_CYCLES(5)) dut5 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .vga_req     (1'b0),
    .vga_addr    (20'h0),
    .vga_ack     (va5),
    .vga_rdata   (vr5),
    .gb_req      (1'b0),
    .gb_we       (1'b0),
    .gb_addr     (16'h0),
    .gb_wdata    (8'h0),
    .gb_ack      (ga5),
    .gb_rdata    (gr5),
    .host_req    (h5_req),
    .host_we     (1'b0),
    .host_addr   (20'h00055),
    .host_be     (2'b11),
    .host_wdata  (16'h0),
    .host_ack    (ha5),
    .host_rdata  (hr5),
    .sram_DQ     (dq5),
    .sram_ADDR   (a5),
    .sram_LB_N   (lb5),
    .sram_UB_N   (ub5),
    .sram_CE_N   (ce5),
    .sram_OE_N   (oe5),
    .sram_WE_N   (we5)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-access observations gathered while waiting for an ack.
  int          s_lat, s_we, s_oe;
  logic [19:0] s_addr;
  logic        s_lb, s_ub;
  logic [15:0] s_dq;

  // which: 0 = VGA, 1 = GB, 2 = host. Call at the negedge the request was raised.
  task automatic wait_ack(input int which);
    bit got = 0;
    s_lat = 0; s_we = 0; s_oe = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      s_lat++;
      if (!sram_CE_N) begin
        s_addr = sram_ADDR; s_lb = sram_LB_N; s_ub = sram_UB_N; s_dq = sram_DQ;
        if (!sram_WE_N) s_we++;
        if (!sram_OE_N) s_oe++;
      end
      if ((which == 0 && vga_ack) || (which == 1 && gb_ack) || (which == 2 && host_ack)) got = 1;
    end
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
    if (which == 0) vga_req = 0;
    if (which == 1) gb_req = 0;
    if (which == 2) host_req = 0;
  endtask

  task automatic host_op(input logic we, input logic [19:0] a, input logic [1:0] be,
                         input logic [15:0] wd);
    host_req = 1; host_we = we; host_addr = a; host_be = be; host_wdata = wd;
    wait_ack(2);
    @(negedge clk);
    chk("host_ack_pulse", 32'(host_ack), 32'd0);
  endtask

  task automatic gb_op(input logic we, input logic [15:0] a, input logic [7:0] wd);
    gb_req = 1; gb_we = we; gb_addr = a; gb_wdata = wd;
    wait_ack(1);
    @(negedge clk);
    chk("gb_ack_pulse", 32'(gb_ack), 32'd0);
  endtask

  initial begin
    int t_vga, t_gb, t_host, cnt, lat, oe;
    int order [8];
    bit re_gb, re_host, seen;

    rst = 1; vga_req = 0; gb_req = 0; host_req = 0; gb_we = 0; host_we = 0;
    vga_addr = 0; host_addr = 0; gb_addr = 0; host_wdata = 0; gb_wdata = 0; host_be = 0;
    h5_req = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_strobes", 32'({sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}), 32'h1f);
    chk("rst_addr", 32'(sram_ADDR), 32'h0);
    chk("rst_dq", 32'(sram_DQ), 32'hffff);
    chk("rst_acks", 32'({vga_ack, gb_ack, host_ack}), 32'h0);
    chk("rst_rdata", 32'({vga_rdata, gb_rdata, host_rdata}), 32'h0);
    rst = 0;
    @(negedge clk);

    // Host write then read-back, with other traffic in between.
    host_op(1, 20'h00123, 2'b11, 16'hBEEF);
    chk("hw_we_cycles", 32'(s_we), 32'd2);
    chk("hw_addr", 32'(s_addr), 32'h00123);
    chk("hw_dq", 32'(s_dq), 32'hBEEF);
    chk("hw_lat", 32'(s_lat), 32'd3);
    host_op(1, 20'h00321, 2'b11, 16'h7E57);
    host_op(1, 20'h14000, 2'b11, 16'hC3A7);
    host_op(0, 20'h00123, 2'b11, 16'h0);
    chk("hr_oe_cycles", 32'(s_oe), 32'd2);
    chk("hr_lat", 32'(s_lat), 32'd3);
    chk("hr_rdata", 32'(host_rdata), 32'hBEEF);

    // Host write with no byte enables must complete but leave memory alone.
    host_op(1, 20'h00123, 2'b00, 16'h0000);
    chk("be0_lanes", 32'({s_ub, s_lb}), 32'h3);
    chk("be0_lat", 32'(s_lat), 32'd3);
    host_op(0, 20'h00123, 2'b11, 16'h0);
    chk("be0_keep", 32'(host_rdata), 32'hBEEF);

    // Game Boy byte lanes in its SRAM window.
    gb_op(1, 16'h8001, 8'h5A);
    chk("gbw_addr", 32'(sram_ADDR), 32'h14000);
    chk("gbw_addr_acc", 32'(s_addr), 32'h14000);
    chk("gbw_lanes", 32'({s_ub, s_lb}), 32'h1);
    chk("gbw_dq", 32'(s_dq), 32'h5A5A);
    gb_op(0, 16'h8001, 8'h0);
    chk("gbr_hi", 32'(gb_rdata), 32'h5A);
    gb_op(0, 16'h8000, 8'h0);
    chk("gbr_lo", 32'(gb_rdata), 32'hA7);

    // Leave the pointer favouring GB, then raise all three together.
    host_op(0, 20'h00321, 2'b11, 16'h0);
    chk("hr2_rdata", 32'(host_rdata), 32'h7E57);
    vga_req = 1; vga_addr = 20'h00321;
    gb_req = 1; gb_we = 0; gb_addr = 16'h8001;
    host_req = 1; host_we = 0; host_addr = 20'h00123; host_be = 2'b11;
    t_vga = 0; t_gb = 0; t_host = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vga_ack)  begin t_vga = i;  vga_req = 0;  end
      if (gb_ack)   begin t_gb = i;   gb_req = 0;   end
      if (host_ack) begin t_host = i; host_req = 0; end
    end
    chk("all3_vga_t", 32'(t_vga), 32'd3);
    chk("all3_gb_t", 32'(t_gb), 32'd7);
    chk("all3_host_t", 32'(t_host), 32'd11);
    chk("all3_vga_rd", 32'(vga_rdata), 32'h7E57);
    chk("all3_gb_rd", 32'(gb_rdata), 32'h5A);
    chk("all3_host_rd", 32'(host_rdata), 32'hBEEF);

    // GB and host both hammering: grants must alternate.
    gb_req = 1; gb_addr = 16'h8000; host_req = 1; host_addr = 20'h00123;
    cnt = 0; re_gb = 0; re_host = 0;
    for (int i = 0; i < 80 && cnt < 8; i++) begin
      @(negedge clk);
      if (re_gb)   begin gb_req = 1;   re_gb = 0;   end
      if (re_host) begin host_req = 1; re_host = 0; end
      if (gb_ack)   begin order[cnt] = 1; cnt++; gb_req = 0;   re_gb = 1;   end
      if (host_ack) begin order[cnt] = 2; cnt++; host_req = 0; re_host = 1; end
    end
    gb_req = 0; host_req = 0;
    chk("rr_count", 32'(cnt), 32'd8);
    for (int j = 0; j < 8; j++) chk("rr_order", 32'(order[j]), (j % 2 == 0) ? 32'd1 : 32'd2);
    @(negedge clk); @(negedge clk);

    // Reset in the middle of a write.
    host_req = 1; host_we = 1; host_addr = 20'h00200; host_be = 2'b11; host_wdata = 16'h1111;
    @(negedge clk);
    chk("midrst_pre_we", 32'(sram_WE_N), 32'd0);
    #2 rst = 1;
    #1;
    chk("midrst_strobes", 32'({sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}), 32'h1f);
    chk("midrst_dq", 32'(sram_DQ), 32'hffff);
    host_req = 0;
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host_ack) seen = 1;
    end
    chk("midrst_no_ack", 32'(seen), 32'd0);
    host_op(0, 20'h00123, 2'b11, 16'h0);
    chk("postrst_lat", 32'(s_lat), 32'd3);
    chk("postrst_rdata", 32'(host_rdata), 32'hBEEF);

    // ACCESS_CYCLES = 5 instance.
    h5_req = 1;
    lat = 0; oe = 0; seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (!oe5) oe++;
      if (ha5) seen = 1;
    end
    h5_req = 0;
    chk("ac5_ack", 32'(seen), 32'd1);
    chk("ac5_oe_cycles", 32'(oe), 32'd5);
    chk("ac5_lat", 32'(lat), 32'd6);
    chk("ac5_rdata", 32'(hr5), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
